// File: rtl/board_io_frontend.sv
// Board I/O front end: reset sequencing from arst/PLL lock, button/switch conditioning,
// sticky button IRQs and registered LEDs. Define BOARD_IO_SW_DEBOUNCE_EN to debounce switches too.

module board_io_debounce #(
  parameter int CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);
  localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Counter only runs while the synchronised input disagrees with the accepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module board_io_frontend #(
  parameter int BTN_NUM         = 5,
  parameter int SW_WIDTH        = 16,
  parameter int LED_WIDTH       = 16,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int RST_STRETCH     = 16
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic                 pll_locked_i,
  input  logic [BTN_NUM-1:0]   btn_i,
  input  logic [SW_WIDTH-1:0]  sw_i,
  input  logic [BTN_NUM-1:0]   irq_mask_i,
  input  logic [BTN_NUM-1:0]   irq_ack_i,
  input  logic [LED_WIDTH-1:0] led_i,
  output logic                 rst_o,
  output logic [BTN_NUM-1:0]   btn_o,
  output logic [SW_WIDTH-1:0]  sw_o,
  output logic [BTN_NUM-1:0]   irq_pending_o,
  output logic                 irq_o,
  output logic [LED_WIDTH-1:0] led_o
);
  localparam int SCW = (RST_STRETCH > 1) ? $clog2(RST_STRETCH) : 1;

  typedef enum logic [1:0] {HOLD, COUNT, RUN} seq_t;

  seq_t           state;
  logic [SCW-1:0] stretch;
  logic [1:0]     lock_sync;
  logic           lock;
  logic [BTN_NUM-1:0] btn_prev;

  assign lock = lock_sync[1];

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) lock_sync <= '0;
    else        lock_sync <= {lock_sync[0], pll_locked_i};
  end

  // Each cycle with lock seen high counts toward the stretch; the last one releases rst_o.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state   <= HOLD;
      stretch <= '0;
      rst_o   <= 1'b1;
    end else if (!lock) begin
      state   <= HOLD;
      stretch <= '0;
      rst_o   <= 1'b1;
    end else if (state != RUN) begin
      if (stretch == SCW'(RST_STRETCH - 1)) begin
        state   <= RUN;
        stretch <= '0;
        rst_o   <= 1'b0;
      end else begin
        state   <= COUNT;
        stretch <= stretch + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < BTN_NUM; i++) begin : g_btn
    board_io_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk_i),
      .rst   (arst_i),
      .raw   (btn_i[i]),
      .level (btn_o[i])
    );
  end

`ifdef BOARD_IO_SW_DEBOUNCE_EN
  for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
    board_io_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk_i),
      .rst   (arst_i),
      .raw   (sw_i[i]),
      .level (sw_o[i])
    );
  end
`else
  logic [SW_WIDTH-1:0] sw_meta;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sw_meta <= '0;
      sw_o    <= '0;
    end else begin
      sw_meta <= sw_i;
      sw_o    <= sw_meta;
    end
  end
`endif

  // Set beats ack; edges during core reset still update btn_prev so held buttons never fire later.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      btn_prev      <= '0;
      irq_pending_o <= '0;
    end else begin
      btn_prev      <= btn_o;
      irq_pending_o <= (irq_pending_o & ~irq_ack_i)
                     | (btn_o & ~btn_prev & irq_mask_i & {BTN_NUM{~rst_o}});
    end
  end

  assign irq_o = |irq_pending_o;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) led_o <= '0;
    else        led_o <= led_i;
  end
endmodule

// File: tb/tb_board_io_frontend.sv
// Directed bench for board_io_frontend: reset sequencing, debounce, IRQ mask/ack, switches, LEDs.

module tb_board_io_frontend;
  localparam int BTN = 2;
  localparam int SW  = 16;
  localparam int LED = 16;
`ifdef BOARD_IO_SW_DEBOUNCE_EN
  localparam int SW_LAT = 6;
`else
  localparam int SW_LAT = 2;
`endif

  logic           clk = 1'b0;
  logic           arst;
  logic           lock;
  logic [BTN-1:0] btn, mask, ack;
  logic [SW-1:0]  sw;
  logic [LED-1:0] led;
  logic           rst_o, irq_o;
  logic [BTN-1:0] btn_o, pend_o;
  logic [SW-1:0]  sw_o;
  logic [LED-1:0] led_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  board_io_frontend #(
    .BTN_NUM(BTN), .SW_WIDTH(SW), .LED_WIDTH(LED),
    .DEBOUNCE_CYCLES(4), .RST_STRETCH(8)
  ) dut (
    .clk_i(clk), .arst_i(arst), .pll_locked_i(lock),
    .btn_i(btn), .sw_i(sw), .irq_mask_i(mask), .irq_ack_i(ack), .led_i(led),
    .rst_o(rst_o), .btn_o(btn_o), .sw_o(sw_o),
    .irq_pending_o(pend_o), .irq_o(irq_o), .led_o(led_o)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    arst = 1'b1; lock = 1'b1; btn = 2'b01; mask = 2'b01; ack = '0;
    sw = '0; led = '0;
    step(3);
    check("reset_rst", rst_o, 1);
    check("reset_btn", btn_o, 0);
    check("reset_sw", sw_o, 0);
    check("reset_pend", pend_o, 0);
    check("reset_irq", irq_o, 0);
    check("reset_led", led_o, 0);

    // Release with lock held and button 0 pressed through boot.
    arst = 1'b0;
    step(6);
    check("boot_btn_up", btn_o[0], 1);
    check("boot_rst_hi", rst_o, 1);
    step(3);
    check("release_e9", rst_o, 1);
    step(1);
    check("release_e10", rst_o, 0);
    step(3);
    check("boot_no_irq", pend_o, 0);
    btn = 2'b00;
    step(8);
    check("fall_btn", btn_o[0], 0);
    check("fall_no_irq", pend_o, 0);

    // Lock drop in the middle of the stretch.
    arst = 1'b1;
    step(2);
    check("rearst_rst", rst_o, 1);
    arst = 1'b0;
    step(6);
    lock = 1'b0;
    step(3);
    check("lockdrop_a", rst_o, 1);
    step(7);
    check("lockdrop_b", rst_o, 1);
    lock = 1'b1;
    step(9);
    check("relock_e9", rst_o, 1);
    step(1);
    check("relock_e10", rst_o, 0);

    // Glitch rejection, then clean press.
    btn = 2'b01;
    step(3);
    btn = 2'b00;
    step(1);
    check("glitch_a", btn_o[0], 0);
    step(6);
    check("glitch_b", btn_o[0], 0);
    btn = 2'b01;
    step(5);
    check("press_e5", btn_o[0], 0);
    step(1);
    check("press_e6", btn_o[0], 1);
    check("press_e6_pend", pend_o[0], 0);
    step(1);
    check("press_e7_pend", pend_o[0], 1);
    check("press_e7_irq", irq_o, 1);

    // Masked press on button 1 is dropped for good.
    btn = 2'b11;
    step(6);
    check("mask_btn1", btn_o[1], 1);
    step(2);
    check("mask_pend1", pend_o[1], 0);
    mask = 2'b11;
    step(3);
    check("mask_late", pend_o, 2'b01);

    // Ack colliding with a new rise: set wins. Then a lone ack clears.
    btn = 2'b10;
    step(8);
    check("ack_rel_btn", btn_o[0], 0);
    check("ack_rel_pend", pend_o[0], 1);
    btn = 2'b11;
    step(6);
    check("ack_rise_btn", btn_o[0], 1);
    ack = 2'b01;
    step(1);
    ack = 2'b00;
    check("ack_collide", pend_o[0], 1);
    ack = 2'b01;
    step(1);
    ack = 2'b00;
    check("ack_clear", pend_o[0], 0);
    check("ack_irq", irq_o, 0);

    // Switch path and LEDs.
    sw = 16'hA5A5;
    step(SW_LAT - 1);
    check("sw_early", sw_o, 16'h0000);
    step(1);
    check("sw_lat", sw_o, 16'hA5A5);
    led = 16'h00FF;
    check("led_before", led_o, 16'h0000);
    step(1);
    check("led_lat", led_o, 16'h00FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
